// File: rtl/peak_detect_ctrl.sv
// peak_detect_ctrl: frame sequencer driving the Q8.8 peak detection datapath
//   cfg_we_i/cfg_*_i : config write, IDLE only       det_*_o : detector clear/enable/sample/config
//   frame_len_i/start_i/abort_i : frame control      det_peak_i/det_filt_i : detector results
//   s_valid_i/s_ready_o/s_data_i : sample stream     pk_*_o/peak_count_o : tagged peak events
//   busy_o/done_o/cfg_err_o : status
module peak_detect_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int LAG_WIDTH  = 6,
  parameter int CNT_WIDTH  = 16,
  parameter int CLEAR_CYC  = 2,
  parameter int PIPE_LAT   = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  cfg_we_i,
  input  logic [LAG_WIDTH-1:0]  cfg_lag_i,
  input  logic [15:0]           cfg_threshold_i,
  input  logic [15:0]           cfg_influence_i,
  input  logic [CNT_WIDTH-1:0]  frame_len_i,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic                  s_valid_i,
  output logic                  s_ready_o,
  input  logic [DATA_WIDTH-1:0] s_data_i,
  output logic                  det_rst_o,
  output logic                  det_en_o,
  output logic [DATA_WIDTH-1:0] det_sample_o,
  output logic [LAG_WIDTH-1:0]  det_lag_o,
  output logic [15:0]           det_threshold_o,
  output logic [15:0]           det_influence_o,
  input  logic                  det_peak_i,
  input  logic [DATA_WIDTH-1:0] det_filt_i,
  output logic                  pk_valid_o,
  output logic [CNT_WIDTH-1:0]  pk_index_o,
  output logic [DATA_WIDTH-1:0] pk_value_o,
  output logic [CNT_WIDTH-1:0]  peak_count_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  cfg_err_o
);
  localparam int CW = $clog2(CLEAR_CYC + PIPE_LAT + 1);
  typedef enum logic [2:0] {IDLE, CLEAR, WARMUP, RUN, DRAIN} state_t;
  typedef struct packed {logic v; logic w; logic [CNT_WIDTH-1:0] idx;} tag_t;
  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [LAG_WIDTH-1:0]  lag_q, lag_d, warm_q, warm_d;
  logic [15:0]           thr_q, thr_d, inf_q, inf_d;
  logic [CNT_WIDTH-1:0]  len_q, len_d, idx_q, idx_d, pk_index_q, pk_index_d, peak_count_q, peak_count_d;
  logic [DATA_WIDTH-1:0] sample_q, sample_d, pk_value_q, pk_value_d;
  logic                  det_rst_q, det_rst_d, pk_valid_q, pk_valid_d, done_q, done_d, cfg_err_q, cfg_err_d;
  tag_t                  det_tag_q, det_tag_d;
  tag_t                  tag_q [PIPE_LAT];
  tag_t                  tag_d [PIPE_LAT];
  logic                  acc, abort_hit, last, peak_hit;
  assign s_ready_o       = state_q == WARMUP || state_q == RUN;
  assign busy_o          = state_q != IDLE;
  assign det_rst_o       = det_rst_q;
  assign det_en_o        = det_tag_q.v;
  assign det_sample_o    = sample_q;
  assign det_lag_o       = lag_q;
  assign det_threshold_o = thr_q;
  assign det_influence_o = inf_q;
  assign pk_valid_o      = pk_valid_q;
  assign pk_index_o      = pk_index_q;
  assign pk_value_o      = pk_value_q;
  assign peak_count_o    = peak_count_q;
  assign done_o          = done_q;
  assign cfg_err_o       = cfg_err_q;
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    lag_d     = lag_q;
    thr_d     = thr_q;
    inf_d     = inf_q;
    warm_d    = warm_q;
    len_d     = len_q;
    done_d    = 1'b0;
    acc       = s_ready_o & s_valid_i;
    abort_hit = abort_i & busy_o;
    last      = acc & (idx_q + CNT_WIDTH'(1) == len_q);
    // the oldest tag lines up with the detector's current result
    peak_hit  = tag_q[PIPE_LAT-1].v & ~tag_q[PIPE_LAT-1].w & det_peak_i & ~abort_hit;
    det_tag_d = {acc, idx_q < CNT_WIDTH'(lag_q), idx_q};
    sample_d  = acc ? s_data_i : sample_q;
    idx_d     = acc ? idx_q + CNT_WIDTH'(1) : idx_q;
    tag_d[0]  = det_tag_q;
    for (int i = 1; i < PIPE_LAT; i++) tag_d[i] = tag_q[i-1];
    pk_valid_d   = peak_hit;
    pk_index_d   = peak_hit ? tag_q[PIPE_LAT-1].idx : pk_index_q;
    pk_value_d   = peak_hit ? det_filt_i : pk_value_q;
    peak_count_d = (peak_hit && !(&peak_count_q)) ? peak_count_q + CNT_WIDTH'(1) : peak_count_q;
    cfg_err_d    = cfg_we_i & (busy_o | (cfg_lag_i < LAG_WIDTH'(2)));
    if (cfg_we_i && !cfg_err_d) begin
      lag_d = cfg_lag_i;
      thr_d = cfg_threshold_i;
      inf_d = cfg_influence_i;
    end
    case (state_q)
      IDLE: if (start_i && !abort_i) begin
        if (frame_len_i == '0) cfg_err_d = 1'b1;
        else begin
          state_d      = CLEAR;
          cnt_d        = '0;
          len_d        = frame_len_i;
          idx_d        = '0;
          warm_d       = '0;
          peak_count_d = '0;
        end
      end
      CLEAR: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(CLEAR_CYC - 1)) begin
          state_d = WARMUP;
          cnt_d   = '0;
        end
      end
      WARMUP: if (acc) begin
        warm_d = warm_q + LAG_WIDTH'(1);
        if (warm_d == lag_q) state_d = RUN;
      end
      RUN: state_d = RUN;
      DRAIN: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(PIPE_LAT)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (last) begin
      state_d = DRAIN;
      cnt_d   = '0;
    end
    if (abort_hit) begin
      state_d     = IDLE;
      done_d      = 1'b0;
      det_tag_d.v = 1'b0;
      for (int i = 0; i < PIPE_LAT; i++) tag_d[i] = '0;
    end
    det_rst_d = (state_d == CLEAR) | abort_hit;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      lag_q        <= LAG_WIDTH'(32);
      thr_q        <= 16'd256;
      inf_q        <= 16'd128;
      warm_q       <= '0;
      len_q        <= '0;
      idx_q        <= '0;
      sample_q     <= '0;
      pk_valid_q   <= 1'b0;
      pk_index_q   <= '0;
      pk_value_q   <= '0;
      peak_count_q <= '0;
      det_rst_q    <= 1'b1;
      done_q       <= 1'b0;
      cfg_err_q    <= 1'b0;
      det_tag_q    <= '0;
      tag_q        <= '{default: '0};
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      lag_q        <= lag_d;
      thr_q        <= thr_d;
      inf_q        <= inf_d;
      warm_q       <= warm_d;
      len_q        <= len_d;
      idx_q        <= idx_d;
      sample_q     <= sample_d;
      pk_valid_q   <= pk_valid_d;
      pk_index_q   <= pk_index_d;
      pk_value_q   <= pk_value_d;
      peak_count_q <= peak_count_d;
      det_rst_q    <= det_rst_d;
      done_q       <= done_d;
      cfg_err_q    <= cfg_err_d;
      det_tag_q    <= det_tag_d;
      tag_q        <= tag_d;
    end
  end
endmodule

// File: tb/tb_peak_detect_ctrl.sv
// tb_peak_detect_ctrl: self-checking bench for peak_detect_ctrl with a one-cycle detector stand-in
module tb_peak_detect_ctrl;
  typedef struct packed {logic [15:0] idx; logic [15:0] val;} pk_t;
  typedef struct {logic [5:0] lag; logic [15:0] thr; logic [15:0] inf; logic err; logic [5:0] e_lag; logic [15:0] e_thr; logic [15:0] e_inf;} cfg_vec_t;
  logic clk, rst_n, cfg_we, start, abort, s_valid, s_ready, det_rst, det_en, det_peak;
  logic pk_valid, busy, done, cfg_err;
  logic [5:0] cfg_lag, det_lag;
  logic [15:0] cfg_threshold, cfg_influence, frame_len, s_data, det_sample, det_threshold, det_influence;
  logic [15:0] det_filt, pk_index, pk_value, peak_count;
  int n_chk, n_pass, cyc_n, en_cnt, pk_cnt, done_cnt, last_en, done_cyc, exp_pk;
  logic [15:0] sb_en[$];
  pk_t sb_pk[$];
  cfg_vec_t vt [6];
  peak_detect_ctrl dut (
    .clk_i(clk), .rst_ni(rst_n), .cfg_we_i(cfg_we), .cfg_lag_i(cfg_lag),
    .cfg_threshold_i(cfg_threshold), .cfg_influence_i(cfg_influence), .frame_len_i(frame_len),
    .start_i(start), .abort_i(abort), .s_valid_i(s_valid), .s_ready_o(s_ready), .s_data_i(s_data),
    .det_rst_o(det_rst), .det_en_o(det_en), .det_sample_o(det_sample), .det_lag_o(det_lag),
    .det_threshold_o(det_threshold), .det_influence_o(det_influence), .det_peak_i(det_peak),
    .det_filt_i(det_filt), .pk_valid_o(pk_valid), .pk_index_o(pk_index), .pk_value_o(pk_value),
    .peak_count_o(peak_count), .busy_o(busy), .done_o(done), .cfg_err_o(cfg_err)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      det_peak <= 1'b0;
      det_filt <= '0;
    end else if (det_rst) begin
      det_peak <= 1'b0;
      det_filt <= '0;
    end else begin
      det_peak <= det_en && det_sample > 16'h0500;
      det_filt <= det_en ? det_sample : det_filt;
    end
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask
  task automatic tick();
    pk_t e;
    @(negedge clk);
    cyc_n++;
    if (det_en) begin
      en_cnt++;
      last_en = cyc_n;
      if (sb_en.size() == 0) chk("det_en_unexpected", 32'(det_en), 32'd0);
      else chk("det_sample", 32'(det_sample), 32'(sb_en.pop_front()));
    end
    if (pk_valid) begin
      pk_cnt++;
      if (sb_pk.size() == 0) chk("pk_unexpected", 32'(pk_valid), 32'd0);
      else begin
        e = sb_pk.pop_front();
        chk("pk_index", 32'(pk_index), 32'(e.idx));
        chk("pk_value", 32'(pk_value), 32'(e.val));
      end
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc_n;
    end
  endtask
  task automatic cfg(input logic [5:0] lag, input logic [15:0] thr, input logic [15:0] inf);
    cfg_we = 1'b1;
    cfg_lag = lag;
    cfg_threshold = thr;
    cfg_influence = inf;
    tick();
    cfg_we = 1'b0;
  endtask
  task automatic start_frame(input int len);
    frame_len = 16'(len);
    start = 1'b1;
    exp_pk = 0;
    tick();
    start = 1'b0;
  endtask
  // mode 0: impulse 0x0A00 at index imp, zero elsewhere; mode 1: 0x0600+index with s_valid toggling
  task automatic send_frame(input int len, input int lag, input int mode, input int imp);
    int i, cyc;
    logic [15:0] d;
    i = 0;
    cyc = 0;
    while (i < len && cyc < 400) begin
      d = (mode == 1) ? 16'h0600 + 16'(i) : ((i == imp) ? 16'h0A00 : 16'h0000);
      s_data = d;
      s_valid = (mode == 1) ? ~cyc[0] : 1'b1;
      if (s_valid && s_ready) begin
        sb_en.push_back(d);
        if (d > 16'h0500 && i >= lag) begin
          sb_pk.push_back(pk_t'{idx: 16'(i), val: d});
          exp_pk++;
        end
        i++;
      end
      tick();
      cyc++;
    end
    s_valid = 1'b0;
    chk("frame_accepts", 32'(i), 32'(len));
  endtask
  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 50) begin
      tick();
      n++;
    end
    chk("done_pulse", 32'(done), 32'd1);
  endtask
  task automatic chk_reset_vals();
    chk("rst_det_rst", 32'(det_rst), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_s_ready", 32'(s_ready), 32'd0);
    chk("rst_det_en", 32'(det_en), 32'd0);
    chk("rst_det_sample", 32'(det_sample), 32'd0);
    chk("rst_pk_valid", 32'(pk_valid), 32'd0);
    chk("rst_peak_count", 32'(peak_count), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_cfg_err", 32'(cfg_err), 32'd0);
    chk("rst_lag", 32'(det_lag), 32'd32);
    chk("rst_threshold", 32'(det_threshold), 32'd256);
    chk("rst_influence", 32'(det_influence), 32'd128);
  endtask
  initial begin
    int en0, pk0, dn0;
    vt[0] = '{6'd1,  16'h0300, 16'h0040, 1'b1, 6'd32, 16'd256,  16'd128};
    vt[1] = '{6'd0,  16'h0300, 16'h0040, 1'b1, 6'd32, 16'd256,  16'd128};
    vt[2] = '{6'd2,  16'h0300, 16'h0040, 1'b0, 6'd2,  16'h0300, 16'h0040};
    vt[3] = '{6'd63, 16'h1234, 16'h00FF, 1'b0, 6'd63, 16'h1234, 16'h00FF};
    vt[4] = '{6'd1,  16'hFFFF, 16'hFFFF, 1'b1, 6'd63, 16'h1234, 16'h00FF};
    vt[5] = '{6'd4,  16'h0200, 16'h0080, 1'b0, 6'd4,  16'h0200, 16'h0080};
    {rst_n, cfg_we, start, abort, s_valid} = '0;
    cfg_lag = '0;
    cfg_threshold = '0;
    cfg_influence = '0;
    frame_len = '0;
    s_data = '0;
    tick();
    tick();
    chk_reset_vals();
    rst_n = 1'b1;
    #1;
    chk("release_det_rst_held", 32'(det_rst), 32'd1);
    tick();
    chk("release_det_rst_drop", 32'(det_rst), 32'd0);
    for (int i = 0; i < 6; i++) begin
      cfg(vt[i].lag, vt[i].thr, vt[i].inf);
      chk("cfg_err", 32'(cfg_err), 32'(vt[i].err));
      chk("cfg_lag", 32'(det_lag), 32'(vt[i].e_lag));
      chk("cfg_threshold", 32'(det_threshold), 32'(vt[i].e_thr));
      chk("cfg_influence", 32'(det_influence), 32'(vt[i].e_inf));
      tick();
      chk("cfg_err_pulse_end", 32'(cfg_err), 32'd0);
    end
    frame_len = 16'd10;
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("collide_busy", 32'(busy), 32'd0);
    chk("collide_det_rst", 32'(det_rst), 32'd0);
    chk("collide_cfg_err", 32'(cfg_err), 32'd0);
    start_frame(0);
    chk("zero_len_cfg_err", 32'(cfg_err), 32'd1);
    chk("zero_len_busy", 32'(busy), 32'd0);
    en0 = en_cnt; pk0 = pk_cnt; dn0 = done_cnt;
    start_frame(10);
    cfg(6'd10, 16'h0100, 16'h0100);
    chk("busy_cfg_err", 32'(cfg_err), 32'd1);
    chk("busy_cfg_lag", 32'(det_lag), 32'd4);
    chk("busy_cfg_threshold", 32'(det_threshold), 32'h0200);
    chk("clear_det_rst", 32'(det_rst), 32'd1);
    chk("clear_s_ready", 32'(s_ready), 32'd0);
    send_frame(10, 4, 0, 6);
    wait_done();
    chk("run_pk_events", 32'(pk_cnt - pk0), 32'd1);
    chk("run_peak_count", 32'(peak_count), 32'(exp_pk));
    chk("run_det_en_count", 32'(en_cnt - en0), 32'd10);
    chk("run_done_latency", 32'(done_cyc - last_en), 32'd2);
    chk("run_pk_pending", 32'(sb_pk.size()), 32'd0);
    tick();
    tick();
    chk("idle_peak_count_hold", 32'(peak_count), 32'd1);
    chk("idle_done_once", 32'(done_cnt - dn0), 32'd1);
    cfg(6'd8, 16'h0200, 16'h0080);
    chk("warm_cfg_err", 32'(cfg_err), 32'd0);
    pk0 = pk_cnt; dn0 = done_cnt;
    start_frame(6);
    send_frame(6, 8, 0, 2);
    wait_done();
    chk("warm_pk_events", 32'(pk_cnt - pk0), 32'd0);
    chk("warm_peak_count", 32'(peak_count), 32'd0);
    chk("warm_done_count", 32'(done_cnt - dn0), 32'd1);
    cfg(6'd2, 16'h0200, 16'h0080);
    en0 = en_cnt; pk0 = pk_cnt;
    start_frame(20);
    send_frame(20, 2, 1, -1);
    wait_done();
    chk("bp_det_en_count", 32'(en_cnt - en0), 32'd20);
    chk("bp_pk_events", 32'(pk_cnt - pk0), 32'd18);
    chk("bp_peak_count", 32'(peak_count), 32'(exp_pk));
    chk("bp_queues_empty", 32'(sb_en.size() + sb_pk.size()), 32'd0);
    cfg(6'd4, 16'h0200, 16'h0080);
    dn0 = done_cnt;
    start_frame(10);
    send_frame(5, 4, 0, -1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_det_rst", 32'(det_rst), 32'd1);
    chk("abort_s_ready", 32'(s_ready), 32'd0);
    chk("abort_det_en", 32'(det_en), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    tick();
    chk("abort_det_rst_one_cycle", 32'(det_rst), 32'd0);
    for (int i = 0; i < 6; i++) tick();
    chk("abort_no_done", 32'(done_cnt - dn0), 32'd0);
    start_frame(10);
    send_frame(3, 4, 0, -1);
    rst_n = 1'b0;
    #1;
    sb_en.delete();
    sb_pk.delete();
    chk_reset_vals();
    tick();
    chk("midrst_det_rst_held", 32'(det_rst), 32'd1);
    rst_n = 1'b1;
    #1;
    chk("midrst_release_det_rst", 32'(det_rst), 32'd1);
    tick();
    chk("midrst_det_rst_drop", 32'(det_rst), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
